// File: rtl/uart_hex_parser_if.sv
// uart_hex_parser_if
// Groups the byte-stream input and the parsed-value output of the hex
// line parser.
//   rx_valid / rx_data : one-cycle byte strobe and byte from the UART receiver
//   value / digit_cnt  : last accepted value and its digit count
//   value_valid        : one-cycle strobe when value/digit_cnt update
//   err                : one-cycle strobe when a line is rejected
//   busy               : parser is inside a line (collecting or discarding)
// Modports: slave = the parser, master = the byte source / value consumer.
interface uart_hex_parser_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [15:0] value;
  logic        value_valid;
  logic [2:0]  digit_cnt;
  logic        err;
  logic        busy;

  modport slave (
    input  rx_valid, rx_data,
    output value, value_valid, digit_cnt, err, busy
  );

  modport master (
    output rx_valid, rx_data,
    input  value, value_valid, digit_cnt, err, busy
  );
endinterface

// File: rtl/uart_hex_parser.sv
// uart_hex_parser
// Turns ASCII hex lines (up to four digits, ended by CR or LF) into a 16-bit
// value with a one-cycle strobe. Bad characters, a fifth digit or an
// inter-byte stall reject the line with a one-cycle err strobe; the rest of a
// rejected line is skipped up to its terminator.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : uart_hex_parser_if.slave (rx_valid/rx_data in; value, value_valid,
//          digit_cnt, err, busy out -- all registered)
module uart_hex_parser #(
  parameter int CLK_FREQ   = 50000000,
  parameter int TIMEOUT_MS = 10
) (
  input  logic              clk,
  input  logic              rst,
  uart_hex_parser_if.slave  bus
);

  localparam logic [31:0] TIMEOUT_CYCLES = 32'((CLK_FREQ / 1000) * TIMEOUT_MS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] acc_reg, acc_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [31:0] tmo_reg, tmo_next;
  logic [15:0] value_reg, value_next;
  logic [2:0]  digit_cnt_reg, digit_cnt_next;
  logic        value_valid_reg, value_valid_next;
  logic        err_reg, err_next;
  logic        busy_reg, busy_next;

  // Character classification of the incoming byte
  logic       is_hex;
  logic       is_term;
  logic       is_blank;
  logic [3:0] nibble;
  logic       tmo_expired;

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
      is_hex = 1'b1;
      nibble = bus.rx_data[3:0];
    end else if ((bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) ||
                 (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 maps them onto 10..15
      is_hex = 1'b1;
      nibble = bus.rx_data[3:0] + 4'd9;
    end
  end

  assign is_term     = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
  assign is_blank    = (bus.rx_data == 8'h20);
  assign tmo_expired = (tmo_reg == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      acc_reg         <= 16'h0000;
      cnt_reg         <= 3'd0;
      tmo_reg         <= 32'd0;
      value_reg       <= 16'h0000;
      digit_cnt_reg   <= 3'd0;
      value_valid_reg <= 1'b0;
      err_reg         <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      acc_reg         <= acc_next;
      cnt_reg         <= cnt_next;
      tmo_reg         <= tmo_next;
      value_reg       <= value_next;
      digit_cnt_reg   <= digit_cnt_next;
      value_valid_reg <= value_valid_next;
      err_reg         <= err_next;
      busy_reg        <= busy_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    acc_next         = acc_reg;
    cnt_next         = cnt_reg;
    tmo_next         = bus.rx_valid ? 32'd0 : tmo_reg + 32'd1;
    value_next       = value_reg;
    digit_cnt_next   = digit_cnt_reg;
    value_valid_next = 1'b0;
    err_next         = 1'b0;

    case (state_reg)
      IDLE: begin
        tmo_next = 32'd0;
        if (bus.rx_valid) begin
          if (is_hex) begin
            acc_next   = {12'h000, nibble};
            cnt_next   = 3'd1;
            state_next = COLLECT;
          end else if (!is_term && !is_blank) begin
            // Empty lines and blanks before a number are silently skipped
            err_next   = 1'b1;
            state_next = DISCARD;
          end
        end
      end

      COLLECT: begin
        if (bus.rx_valid) begin
          if (is_hex) begin
            if (cnt_reg == 3'd4) begin
              err_next   = 1'b1;
              state_next = DISCARD;
            end else begin
              acc_next = {acc_reg[11:0], nibble};
              cnt_next = cnt_reg + 3'd1;
            end
          end else if (is_term) begin
            value_next       = acc_reg;
            digit_cnt_next   = cnt_reg;
            value_valid_next = 1'b1;
            state_next       = IDLE;
          end else begin
            err_next   = 1'b1;
            state_next = DISCARD;
          end
        end else if (tmo_expired) begin
          // A byte arriving on the expiry cycle takes the branch above instead
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end

      DISCARD: begin
        if (bus.rx_valid) begin
          if (is_term) begin
            state_next = IDLE;
          end
        end else if (tmo_expired) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered copy of the state decode so busy leaves the block from a flop
  assign busy_next = (state_next != IDLE);

  assign bus.value       = value_reg;
  assign bus.digit_cnt   = digit_cnt_reg;
  assign bus.value_valid = value_valid_reg;
  assign bus.err         = err_reg;
  assign bus.busy        = busy_reg;

endmodule
